// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared width/latency helpers for the matrix-vector datapath
package matvec_pkg;

    // Result width: full product plus adder-tree growth plus accumulation growth
    function automatic int calc_w_y(input int w_x, input int w_k, input int c, input int max_tiles);
        return w_x + w_k + $clog2(c) + $clog2(max_tiles);
    endfunction

    // Input handshake to result valid: product stage, tree levels, accumulate stage
    function automatic int calc_lat(input int c);
        return $clog2(c) + 2;
    endfunction

endpackage

// File: rtl/matvec_row_tree.sv
// rtl/matvec_row_tree.sv - one output row: C_PAD multipliers feeding a registered adder tree
module matvec_row_tree #(
    parameter int C      = 8,
    parameter int W_X    = 8,
    parameter int W_K    = 8,
    parameter int W_Y    = 20,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [C*W_K-1:0] k_i,
    input  logic [C*W_X-1:0] x_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [W_Y-1:0]   sum_o
);

    localparam int DEPTH  = $clog2(C);
    localparam int C_PAD  = 1 << DEPTH;
    localparam int W_M    = W_X + W_K;
    localparam int N_NODE = 2 * C_PAD - 1;

    // Heap layout: node 0 is the root, children of i are 2i+1 and 2i+2,
    // leaves (registered products) occupy C_PAD-1 .. 2*C_PAD-2.
    logic [W_Y-1:0] node_q [N_NODE];
    logic [W_Y-1:0] leaf_w [C_PAD];
    logic [DEPTH:0] valid_q;
    logic [DEPTH:0] last_q;

    for (genvar j = 0; j < C_PAD; j++) begin : g_leaf
        if (j < C) begin : g_mul
            logic           k_s;
            logic           x_s;
            logic           p_s;
            logic [W_M-1:0] k_w;
            logic [W_M-1:0] x_w;
            logic [W_M-1:0] prod;

            // Extending both operands to W_M bits lets one unsigned multiplier
            // serve both modes; the low W_M bits equal the exact product.
            assign k_s    = (SIGNED != 0) & k_i[j*W_K + W_K - 1];
            assign x_s    = (SIGNED != 0) & x_i[j*W_X + W_X - 1];
            assign k_w    = {{W_X{k_s}}, k_i[j*W_K +: W_K]};
            assign x_w    = {{W_K{x_s}}, x_i[j*W_X +: W_X]};
            assign prod   = k_w * x_w;
            assign p_s    = (SIGNED != 0) & prod[W_M-1];
            assign leaf_w[j] = {{(W_Y-W_M){p_s}}, prod};
        end else begin : g_pad
            assign leaf_w[j] = '0;
        end
    end

    // Tree data: products into the leaves, one pairwise-add level per stage
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int j = 0; j < C_PAD; j++) begin
                node_q[C_PAD-1+j] <= leaf_w[j];
            end
            for (int i = 0; i < C_PAD - 1; i++) begin
                node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
            end
        end
    end

    // Valid/last sideband shifts alongside the tree levels
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
        end else if (en_i) begin
            valid_q <= {valid_q[DEPTH-1:0], valid_i};
            last_q  <= {last_q[DEPTH-1:0], last_i};
        end
    end

    assign valid_o = valid_q[DEPTH];
    assign last_o  = last_q[DEPTH];
    assign sum_o   = node_q[0];

endmodule

// File: rtl/matvec_mul_stream.sv
// rtl/matvec_mul_stream.sv - streaming tiled matrix-vector multiplier with per-row accumulation
module matvec_mul_stream
    import matvec_pkg::*;
#(
    parameter int R         = 8,
    parameter int C         = 8,
    parameter int W_X       = 8,
    parameter int W_K       = 8,
    parameter int MAX_TILES = 4,
    parameter int SIGNED    = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [R*C*W_K-1:0]                          s_k,
    input  logic [C*W_X-1:0]                            s_x,
    input  logic                                        s_last,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [R*calc_w_y(W_X, W_K, C, MAX_TILES)-1:0] m_y,
    output logic                                        ovf
);

    localparam int W_Y = calc_w_y(W_X, W_K, C, MAX_TILES);
    localparam int CW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    logic                  en;
    logic [R-1:0]          tree_valid;
    logic [R-1:0]          tree_last;
    logic [R-1:0][W_Y-1:0] tree_sum;
    logic                  row_valid;
    logic                  row_last;

    logic [R-1:0][W_Y-1:0] acc_q,  acc_d;
    logic [R-1:0][W_Y-1:0] m_y_q,  m_y_d;
    logic [R-1:0][W_Y-1:0] sum_w;
    logic                  m_valid_q, m_valid_d;
    logic                  first_q,   first_d;
    logic                  ovf_q,     ovf_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic                  seq_end;

    // A held result blocks everything; otherwise the whole pipe moves
    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;

    for (genvar r = 0; r < R; r++) begin : g_row
        matvec_row_tree #(
            .C      (C),
            .W_X    (W_X),
            .W_K    (W_K),
            .W_Y    (W_Y),
            .SIGNED (SIGNED)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .valid_i (s_valid),
            .last_i  (s_last),
            .k_i     (s_k[r*C*W_K +: C*W_K]),
            .x_i     (s_x),
            .valid_o (tree_valid[r]),
            .last_o  (tree_last[r]),
            .sum_o   (tree_sum[r])
        );
    end

    // Every row carries identical sideband; reducing them keeps all rows in use
    assign row_valid = &tree_valid;
    assign row_last  = &tree_last;

    // Accumulate/output next state: fold tree sums, close sequences, retire results
    always_comb begin
        acc_d     = acc_q;
        m_y_d     = m_y_q;
        m_valid_d = m_valid_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        seq_end   = row_last || (cnt_q == CW'(MAX_TILES - 1));
        for (int r = 0; r < R; r++) begin
            sum_w[r] = first_q ? tree_sum[r] : acc_q[r] + tree_sum[r];
        end
        if (en) begin
            // en means any held result is being taken this cycle
            m_valid_d = 1'b0;
            if (row_valid) begin
                if (seq_end) begin
                    m_y_d     = sum_w;
                    m_valid_d = 1'b1;
                    first_d   = 1'b1;
                    cnt_d     = '0;
                    if (!row_last) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    acc_d   = sum_w;
                    first_d = 1'b0;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
        end
    end

    // Accumulator, sequence tracking and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            m_y_q     <= '0;
            m_valid_q <= 1'b0;
            first_q   <= 1'b1;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            m_y_q     <= m_y_d;
            m_valid_q <= m_valid_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_y     = m_y_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_matvec_mul_stream.sv
// tb/tb_matvec_mul_stream.sv - scoreboard bench for matvec_mul_stream (signed and unsigned instances)
module tb_matvec_mul_stream;

    localparam int R         = 2;
    localparam int C         = 3;
    localparam int W_X       = 8;
    localparam int W_K       = 8;
    localparam int MAX_TILES = 4;
    localparam int W_Y       = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 s_valid = 1'b0;
    logic                 s_last  = 1'b0;
    logic                 m_ready = 1'b1;
    logic [R*C*W_K-1:0]   s_k     = '0;
    logic [C*W_X-1:0]     s_x     = '0;
    logic                 s_ready_s, s_ready_u;
    logic                 m_valid_s, m_valid_u;
    logic                 ovf_s, ovf_u;
    logic [R*W_Y-1:0]     m_y_s, m_y_u;

    matvec_mul_stream #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_TILES(MAX_TILES), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s), .s_k(s_k), .s_x(s_x),
        .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready), .m_y(m_y_s), .ovf(ovf_s)
    );

    matvec_mul_stream #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_TILES(MAX_TILES), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_u), .s_k(s_k), .s_x(s_x),
        .s_last(s_last), .m_valid(m_valid_u), .m_ready(m_ready), .m_y(m_y_u), .ovf(ovf_u)
    );

    typedef struct packed {
        logic [W_Y-1:0] ys1;
        logic [W_Y-1:0] ys0;
        logic [W_Y-1:0] yu1;
        logic [W_Y-1:0] yu0;
        logic           ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    bit     auto_model = 1'b0;
    bit     rand_bp = 1'b0;
    int     hold_req = 0;
    longint ms[R];
    longint mu[R];
    int     mcnt = 0;
    bit     movf = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [R*C*W_K-1:0] mk_k(input int a0, input int a1, input int a2,
                                                input int b0, input int b1, input int b2);
        return {8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [C*W_X-1:0] mk_x(input int x0, input int x1, input int x2);
        return {8'(x2), 8'(x1), 8'(x0)};
    endfunction

    task automatic push_exp(input int ys0, input int ys1, input int yu0, input int yu1, input bit ov);
        exp_t e;
        e.ys0 = W_Y'(ys0);
        e.ys1 = W_Y'(ys1);
        e.yu0 = W_Y'(yu0);
        e.yu1 = W_Y'(yu1);
        e.ovf = ov;
        exp_q.push_back(e);
    endtask

    task automatic model_accept(input logic [R*C*W_K-1:0] k, input logic [C*W_X-1:0] x, input logic last);
        logic [7:0] kb, xb;
        int ks, xs, ku, xu;
        exp_t e;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                kb = k[(r*C+c)*W_K +: W_K];
                xb = x[c*W_X +: W_X];
                ks = $signed(kb);
                xs = $signed(xb);
                ku = kb;
                xu = xb;
                ms[r] += longint'(ks * xs);
                mu[r] += longint'(ku * xu);
            end
        end
        mcnt++;
        if (last || mcnt == MAX_TILES) begin
            if (!last) movf = 1'b1;
            e.ys0 = W_Y'(ms[0]);
            e.ys1 = W_Y'(ms[1]);
            e.yu0 = W_Y'(mu[0]);
            e.yu1 = W_Y'(mu[1]);
            e.ovf = movf;
            exp_q.push_back(e);
            for (int r = 0; r < R; r++) begin
                ms[r] = 0;
                mu[r] = 0;
            end
            mcnt = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake
    task automatic send(input logic [R*C*W_K-1:0] k, input logic [C*W_X-1:0] x, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_k     = k;
        s_x     = x;
        s_last  = last;
        while (!s_ready_s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_s) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready got 0 expected 1 within 1000 cycles");
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (auto_model) model_accept(k, x, last);
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid_s) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Downstream ready: forced hold windows, random stalls, or always ready
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold_req > 0) begin
                m_ready = 1'b0;
                hold_req--;
            end else begin
                m_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: pop expected on every output handshake, check stability under stall
    initial begin
        exp_t             e;
        logic             stall_prev;
        logic [R*W_Y-1:0] y_hold;
        stall_prev = 1'b0;
        y_hold     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                continue;
            end
            if (m_valid_s && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got m_y %h with no result expected", m_y_s);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {m_y_s, m_y_u, ovf_s, m_valid_u},
                          {e.ys1, e.ys0, e.yu1, e.yu0, e.ovf, 1'b1});
                end
            end
            if (m_valid_s && !m_ready) begin
                check("stall_ready", {s_ready_s, s_ready_u}, 2'b00);
                if (stall_prev) check("stall_hold", m_y_s, y_hold);
                stall_prev = 1'b1;
                y_hold     = m_y_s;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [R*C*W_K-1:0] rk;
        logic [C*W_X-1:0]   rx;
        int n, len;
        bit forced;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {m_valid_s, m_valid_u, ovf_s, ovf_u, m_y_s, m_y_u}, '0);
        check("reset_ready", {s_ready_s, s_ready_u}, 2'b11);

        // Single tile and latency
        push_exp(32, -32, 32, 3808, 1'b0);
        send(mk_k(1, 2, 3, -1, -2, -3), mk_x(4, 5, 6), 1'b1);
        n = 1;
        while (!m_valid_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 4);
        drain();

        // Two-tile sequence
        push_exp(35, -26, 35, 3814, 1'b0);
        send(mk_k(1, 2, 3, -1, -2, -3), mk_x(4, 5, 6), 1'b0);
        send(mk_k(1, 1, 1, 2, 2, 2), mk_x(1, 1, 1), 1'b1);
        drain();

        // Operand extremes over a full MAX_TILES sequence
        push_exp(196608, 196608, 196608, 196608, 1'b0);
        for (int i = 0; i < 4; i++)
            send(mk_k(-128, -128, -128, -128, -128, -128), mk_x(-128, -128, -128), i == 3);
        push_exp(12, 12, 780300, 780300, 1'b0);
        for (int i = 0; i < 4; i++)
            send(mk_k(255, 255, 255, 255, 255, 255), mk_x(255, 255, 255), i == 3);
        drain();

        // Forced termination at MAX_TILES; the fifth tile opens a new sequence
        push_exp(12, 12, 12, 12, 1'b1);
        push_exp(6, 6, 6, 6, 1'b1);
        for (int i = 0; i < 5; i++)
            send(mk_k(1, 1, 1, 1, 1, 1), mk_x(1, 1, 1), 1'b0);
        send(mk_k(1, 1, 1, 1, 1, 1), mk_x(1, 1, 1), 1'b1);
        drain();

        // Reset after two of three tiles
        send(mk_k(1, 1, 1, 1, 1, 1), mk_x(1, 1, 1), 1'b0);
        send(mk_k(1, 1, 1, 1, 1, 1), mk_x(1, 1, 1), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset", {m_valid_s, m_valid_u, ovf_s, ovf_u}, 4'b0000);
        push_exp(32, -32, 32, 3808, 1'b0);
        send(mk_k(1, 2, 3, -1, -2, -3), mk_x(4, 5, 6), 1'b1);
        drain();

        // Held backpressure under continuous input, then random sequences with random stalls
        for (int r = 0; r < R; r++) begin
            ms[r] = 0;
            mu[r] = 0;
        end
        mcnt = 0;
        movf = 1'b0;
        auto_model = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rk[31:0]  = $urandom();
            rk[47:32] = 16'($urandom());
            rx        = 24'($urandom());
            send(rk, rx, 1'b1);
        end
        hold_req = 5;
        rand_bp  = 1'b1;
        for (int s = 0; s < 200; s++) begin
            forced = ($urandom_range(0, 9) == 0);
            len    = forced ? MAX_TILES : $urandom_range(1, MAX_TILES);
            for (int i = 0; i < len; i++) begin
                rk[31:0]  = $urandom();
                rk[47:32] = 16'($urandom());
                rx        = 24'($urandom());
                send(rk, rx, !forced && (i == len - 1));
            end
        end
        rand_bp = 1'b0;
        drain();
        auto_model = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
